// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered ready/valid sink among NUM_REQ requesters, bursts of up to MAX_BURST beats.
// Grant one cycle after request, beat visible one cycle after accept; req_ready drops whenever the output register cannot take a beat.
module stream_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [15:0]                   beat_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         gidx, gidx_nxt;
    logic [IW-1:0]         last, last_nxt;
    logic [3:0]            burst, burst_nxt;
    logic [IW-1:0]         pick_idx, cand;
    logic                  pick_vld;
    logic                  space, accept, sink_hs, g_vld;
    logic [DATA_WIDTH-1:0] gdata;

    assign space   = !out_valid || out_ready;
    assign sink_hs = out_valid && out_ready;
    assign g_vld   = req_valid[gidx];
    assign busy    = (state == GRANT);

    // Search starts one past the last released requester so nobody is starved.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last) + i) % NUM_REQ);
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        gdata = '0;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx == IW'(i)) gdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            grant[i] = busy && (gidx == IW'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        last_nxt  = last;
        burst_nxt = burst;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    gidx_nxt  = pick_idx;
                    burst_nxt = '0;
                end
            end
            GRANT: begin
                req_ready[gidx] = space && g_vld;
                accept          = space && g_vld;
                if (accept) burst_nxt = burst + 4'd1;
                // A requester dropping valid gives up the grant even while the sink stalls.
                if (!g_vld || (accept && (burst + 4'd1 == 4'(MAX_BURST)))) begin
                    state_nxt = IDLE;
                    last_nxt  = gidx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gidx       <= '0;
            last       <= IW'(NUM_REQ - 1);
            burst      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            beat_count <= '0;
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            last  <= last_nxt;
            burst <= burst_nxt;
            if (accept) begin
                out_data  <= gdata;
                out_valid <= 1'b1;
            end else if (sink_hs) begin
                out_valid <= 1'b0;
            end
            beat_count <= beat_count + {15'd0, sink_hs};
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: queue-fed requesters, expected-beat scoreboard, table-driven cycle checks.
module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] beat_count;

    stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .grant(grant), .busy(busy), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ordy;
        logic [3:0] grant;
        logic       busy;
        logic       ov;
        logic [7:0] od;
        logic [3:0] rdy;
    } vec_t;

    logic [7:0]  src_q [4][$];
    logic [7:0]  exp_q [$];
    logic [3:0]  en = 4'hF;
    logic [3:0]  hs_prev = '0;
    logic        rst_cfg = 1'b1;
    logic        ordy_cfg = 1'b1;
    logic        sb_en = 1'b1;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic src_empty();
        logic e = 1'b1;
        for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // One clock: drive just after posedge, observe and score at negedge.
    task automatic step();
        @(posedge clk);
        #1;
        reset     = rst_cfg;
        out_ready = ordy_cfg;
        for (int i = 0; i < 4; i++) if (hs_prev[i]) void'(src_q[i].pop_front());
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = en[i] && (src_q[i].size() != 0);
            req_data[i*8 +: 8]  = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
        end
        @(negedge clk);
        hs_prev = reset ? 4'h0 : (req_valid & req_ready);
        if (sb_en && !reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
            else check("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_reset();
        rst_cfg = 1'b1;
        step();
        step();
        rst_cfg = 1'b0;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int lim);
        for (int k = 0; k < lim; k++) begin
            if (exp_q.size() == 0 && src_empty() && !out_valid) break;
            step();
        end
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_idle"}, {31'd0, out_valid}, 0);
    endtask

    vec_t        t1 [12];
    logic [3:0]  t2_exp [5];
    logic [3:0]  gseq [$];
    logic [3:0]  prev_g;
    logic [15:0] seen [$];
    logic [15:0] prev_bc;
    int          pushed;

    initial begin
        //          ordy  grant  busy  ov    od     rdy
        t1[0]  = {1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
        t1[1]  = {1'b1, 4'h4, 1'b1, 1'b0, 8'h00, 4'h4};
        t1[2]  = {1'b1, 4'h4, 1'b1, 1'b1, 8'h10, 4'h4};
        t1[3]  = {1'b1, 4'h4, 1'b1, 1'b1, 8'h11, 4'h4};
        t1[4]  = {1'b1, 4'h4, 1'b1, 1'b1, 8'h12, 4'h4};
        t1[5]  = {1'b1, 4'h0, 1'b0, 1'b1, 8'h13, 4'h0};
        t1[6]  = {1'b1, 4'h4, 1'b1, 1'b0, 8'h13, 4'h4};
        t1[7]  = {1'b1, 4'h4, 1'b1, 1'b1, 8'h14, 4'h4};
        t1[8]  = {1'b1, 4'h4, 1'b1, 1'b1, 8'h15, 4'h4};
        t1[9]  = {1'b1, 4'h4, 1'b1, 1'b1, 8'h16, 4'h4};
        t1[10] = {1'b1, 4'h0, 1'b0, 1'b1, 8'h17, 4'h0};
        t1[11] = {1'b1, 4'h0, 1'b0, 1'b0, 8'h17, 4'h0};
        t2_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_beat_count", {16'd0, beat_count}, 0);
        check("rst_req_ready", {28'd0, req_ready}, 0);

        // T1: single requester, burst split with one idle cycle
        for (int k = 0; k < 8; k++) begin
            src_q[2].push_back(8'h10 + 8'(k));
            exp_q.push_back(8'h10 + 8'(k));
        end
        for (int c = 0; c < 12; c++) begin
            ordy_cfg = t1[c].ordy;
            step();
            check($sformatf("t1_grant_c%0d", c), {28'd0, grant}, {28'd0, t1[c].grant});
            check($sformatf("t1_busy_c%0d", c), {31'd0, busy}, {31'd0, t1[c].busy});
            check($sformatf("t1_ov_c%0d", c), {31'd0, out_valid}, {31'd0, t1[c].ov});
            check($sformatf("t1_od_c%0d", c), {24'd0, out_data}, {24'd0, t1[c].od});
            check($sformatf("t1_rdy_c%0d", c), {28'd0, req_ready}, {28'd0, t1[c].rdy});
        end
        drain("t1", 50);

        // T2: all four requesters contend
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(8'h80 | 8'(i << 4) | 8'(k));
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) exp_q.push_back(8'h80 | 8'(i << 4) | 8'(h*4 + k));
        prev_g = '0;
        for (int k = 0; k < 200 && gseq.size() < 5; k++) begin
            step();
            if (grant != 4'h0 && prev_g == 4'h0) begin
                gseq.push_back(grant);
                if (gseq.size() == 5) check("t2_beats_after_4_grants", {16'd0, beat_count}, 16);
            end
            prev_g = grant;
        end
        check("t2_grants_seen", gseq.size(), 5);
        for (int i = 0; i < gseq.size() && i < 5; i++)
            check($sformatf("t2_grant%0d", i), {28'd0, gseq[i]}, {28'd0, t2_exp[i]});
        drain("t2", 200);

        // T3: sink stall holds the output beat
        ordy_cfg = 1'b0;
        src_q[1].push_back(8'hA5); src_q[1].push_back(8'hA6); src_q[1].push_back(8'hA7);
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA6); exp_q.push_back(8'hA7);
        step();
        step();
        check("t3_grant", {28'd0, grant}, 32'h2);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("t3_stall_od%0d", k), {24'd0, out_data}, 32'hA5);
            check($sformatf("t3_stall_ov%0d", k), {31'd0, out_valid}, 1);
            check($sformatf("t3_stall_rdy%0d", k), {28'd0, req_ready}, 0);
        end
        ordy_cfg = 1'b1;
        step();
        check("t3_release_rdy", {28'd0, req_ready}, 32'h2);
        check("t3_release_od", {24'd0, out_data}, 32'hA5);
        step();
        check("t3_next_od", {24'd0, out_data}, 32'hA6);
        check("t3_next_ov", {31'd0, out_valid}, 1);
        drain("t3", 50);

        // T4: requester drops valid mid-burst, waiting requester takes over
        do_reset();
        src_q[1].push_back(8'h31); src_q[1].push_back(8'h32);
        src_q[3].push_back(8'h71); src_q[3].push_back(8'h72); src_q[3].push_back(8'h73);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        exp_q.push_back(8'h71); exp_q.push_back(8'h72); exp_q.push_back(8'h73);
        step();
        step();
        check("t4_grant1", {28'd0, grant}, 32'h2);
        step();
        step();
        check("t4_drop_busy", {31'd0, busy}, 1);
        check("t4_drop_grant", {28'd0, grant}, 32'h2);
        check("t4_drop_rdy", {28'd0, req_ready}, 0);
        step();
        check("t4_idle_grant", {28'd0, grant}, 0);
        check("t4_idle_busy", {31'd0, busy}, 0);
        step();
        check("t4_grant3", {28'd0, grant}, 32'h8);
        drain("t4", 50);

        // T5: reset in the middle of a burst
        for (int k = 0; k < 6; k++) begin
            src_q[2].push_back(8'h51 + 8'(k));
            exp_q.push_back(8'h51 + 8'(k));
        end
        for (int k = 0; k < 4; k++) src_q[0].push_back(8'h01 + 8'(k));
        en = 4'b1110;
        step();
        step();
        check("t5_grant2", {28'd0, grant}, 32'h4);
        en = 4'hF;
        step();
        rst_cfg = 1'b1;
        step();
        rst_cfg = 1'b0;
        step();
        check("t5_rst_ov", {31'd0, out_valid}, 0);
        check("t5_rst_od", {24'd0, out_data}, 0);
        check("t5_rst_grant", {28'd0, grant}, 0);
        check("t5_rst_bc", {16'd0, beat_count}, 0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h01 + 8'(k));
        for (int k = 2; k < 6; k++) exp_q.push_back(8'h51 + 8'(k));
        step();
        check("t5_first_grant", {28'd0, grant}, 32'h1);
        drain("t5", 100);

        // T6: beat counter wrap
        do_reset();
        sb_en  = 1'b0;
        pushed = 0;
        for (int k = 0; k < 90000; k++) begin
            for (int i = 0; i < 2; i++)
                if (src_q[i].size() < 2 && pushed < 65534) begin
                    src_q[i].push_back(8'(pushed));
                    pushed++;
                end
            step();
            if (pushed == 65534 && src_empty() && !out_valid) break;
        end
        sb_en = 1'b1;
        check("t6_preload", {16'd0, beat_count}, 32'hFFFE);
        src_q[1].push_back(8'hC1); src_q[1].push_back(8'hC2); src_q[1].push_back(8'hC3);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        prev_bc = beat_count;
        for (int k = 0; k < 12; k++) begin
            step();
            if (beat_count != prev_bc) begin
                seen.push_back(beat_count);
                prev_bc = beat_count;
            end
        end
        check("t6_changes", seen.size(), 3);
        if (seen.size() > 0) check("t6_bc0", {16'd0, seen[0]}, 32'hFFFF);
        if (seen.size() > 1) check("t6_bc1", {16'd0, seen[1]}, 32'h0000);
        if (seen.size() > 2) check("t6_bc2", {16'd0, seen[2]}, 32'h0001);
        drain("t6", 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
